// File: rtl/lii_rx_unpacker.sv
// Receive-side LII wrapper: filters phy words by destination, buffers them in a
// small word FIFO and unpacks each word into PW/DW kernel beats, LSB lane first.
module lii_rx_unpacker #(
  parameter int          PW       = 64,
  parameter int          DW       = 16,
  parameter logic [7:0]  LOCAL_ID = 8'h00,
  parameter int          DEPTH    = 4
) (
  input  logic          aclk,
  input  logic          arstn,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  output logic          lii_in_p0_tready,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic [DW-1:0] img_stream_tdata,
  output logic          img_stream_tvalid,
  input  logic          img_stream_tready,
  output logic          ce,
  output logic [15:0]   drop_cnt
);

  localparam int LANES = PW / DW;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  logic          rdy_en_reg;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [LW-1:0] lane_reg, lane_next;
  logic [15:0]   drop_cnt_reg, drop_cnt_next;

  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] head_word;
  logic [DW-1:0] lanes [LANES];

  logic full, empty, in_hs, push, drop, out_hs, last_lane, pop;

  // Source ID is sideband only; it takes no part in filtering.
  logic unused_src;
  assign unused_src = ^lii_in_p0_src;

  assign full              = (count_reg == DEPTH_C);
  assign empty             = (count_reg == '0);
  assign lii_in_p0_tready  = rdy_en_reg && !full;
  assign in_hs             = lii_in_p0_tvalid && lii_in_p0_tready;
  assign push              = in_hs && (lii_in_p0_dst == LOCAL_ID);
  assign drop              = in_hs && (lii_in_p0_dst != LOCAL_ID);

  assign img_stream_tvalid = !empty;
  assign ce                = img_stream_tvalid;
  assign out_hs            = img_stream_tvalid && img_stream_tready;
  assign last_lane         = (lane_reg == LAST_LANE);
  assign pop               = out_hs && last_lane;
  assign drop_cnt          = drop_cnt_reg;

  assign head_word = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes[gi] = head_word[gi*DW +: DW];
    end
  endgenerate

  assign img_stream_tdata = lanes[lane_reg];

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    lane_next     = lane_reg;
    drop_cnt_next = drop_cnt_reg;

    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);

    if (out_hs) lane_next = last_lane ? '0 : lane_reg + LW'(1);

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    if (drop && (drop_cnt_reg != 16'hFFFF)) drop_cnt_next = drop_cnt_reg + 16'd1;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rdy_en_reg   <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      lane_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      rdy_en_reg   <= 1'b1;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      lane_reg     <= lane_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Word storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_reg] <= lii_in_p0_tdata;
  end

endmodule
